c_credit_flit_sender: RTL and testbench
=======================================

# c_credit_flit_sender

Credit-gated output stage for a point-to-point flit link. It accepts flits from the local pipeline through a valid/ready handshake and holds them in a two-entry buffer. It launches a flit only when the downstream FIFO has a free entry, as reported by the FIFO tracker's `full`/`almost_full` outputs. Its launch strobe is the tracker's `push`, so the block sits directly upstream of, and in a closed loop with, the credit tracker.

## Interface
- `data_width`, 32, flit payload width in bits.

- `clk`  in  1  clock; single clock domain.
- `reset`  in  1  reset; synchronous, active-high.
- `active`  in  1  clock enable; all registers hold when low.
- `in_valid`  in  1  upstream flit valid.
- `in_data`  in  data_width  upstream flit payload.
- `in_ready`  out  1  block can accept a flit this cycle.
- `credit_full`  in  1  tracker `full`; downstream FIFO has no free entry.
- `credit_almost_full`  in  1  tracker `almost_full`; used only for statistics and assertions.
- `out_valid`  out  1  flit launched this cycle; drives tracker `push`.
- `out_data`  out  data_width  launched payload.
- `stall_count`  out  16  credit-stall cycle count (see Configuration).
- `errors`  out  [0:1]  {`error_in_overflow`, `error_credit_violation`}.

## Operation
- Storage: head register plus skid register, each holding payload and valid. Occupancy state takes values EMPTY, ONE and TWO.
- `accept = in_valid & in_ready`
- `send = head_valid & ~credit_full & active`
- `out_valid = send` and `out_data = head_data`, both combinational from registers.
- `in_ready = active & (state != TWO)`. It decodes registered state only and has no combinational path from `credit_full`.
- State transitions:
  - EMPTY: on `accept`, load head and go to ONE. Otherwise stay in EMPTY. `send` is impossible.
  - ONE, `accept & ~send`: load skid and go to TWO.
  - ONE, `~accept & send`: clear head and go to EMPTY.
  - ONE, `accept & send`: load head with `in_data` and stay in ONE.
  - ONE, neither: hold.
  - TWO, `send`: move skid to head, clear skid, go to ONE. `accept` is impossible because `in_ready` is 0.
  - TWO, no `send`: hold.
- Ordering is strict FIFO and no flit is ever dropped or duplicated.
- `error_in_overflow = in_valid & ~in_ready & active`. The offered flit is ignored and not stored.
- `error_credit_violation = out_valid & credit_full`. It must be structurally 0 and exists for assertion coverage.
- Returned credits do not enter this block; they drive tracker `pop` directly. A credit returned in a full cycle becomes visible as `credit_full`=0 on the following cycle.

## Timing
- Reset values: state EMPTY, head/skid valid 0, payload registers 0, `in_ready` 1 (given `active`=1), `out_valid` 0, `out_data` 0, `stall_count` 0, `errors` 00.
- Minimum latency is 1 cycle: a flit accepted in cycle N can launch in cycle N+1. There is no same-cycle bypass.
- Throughput is 1 flit/cycle sustained while `credit_full`=0.
- `credit_almost_full`=1 with a send in cycle N causes the tracker to raise `credit_full` in N+1. The block stalls in N+1 without further logic.
- Reset mid-operation: buffered flits are discarded. The block is in EMPTY from the cycle after `reset` is sampled high.
- `active`=0: `out_valid`=0, `in_ready`=0, and state is frozen.

## Configuration
- `C_FLIT_SENDER_STATS_EN`, when defined:
  - `stall_count` increments each cycle where `head_valid & credit_full & active`.
  - The counter saturates at 16'hFFFF and clears on reset.
  - It also counts, internally, cycles where `credit_almost_full & send`. This count is used only by bench assertions and has no port.
- Without the macro, `stall_count` is tied to 16'h0000 and no counter flops exist.

## Test plan
- Reset release, `credit_full`=0, stream of 4 flits with `in_valid`=1 each cycle -> `in_ready` stays 1, `out_data` emits D0..D3 on cycles N+1..N+4, one per cycle, `out_valid`=1 exactly 4 cycles.
- Hold `credit_full`=1, offer 3 flits -> first two accepted (state TWO), `in_ready`=0 from the cycle after the second accept, third offer raises `error_in_overflow` for that cycle only, `out_valid` stays 0.
- From TWO, drop `credit_full` for 1 cycle -> exactly one flit (oldest) launches, state ONE, `in_ready`=1 next cycle; a later drop launches the second flit in order.
- Tracker loop with depth=2: sender pushes until `full`, then pop one credit per 3 cycles -> sender launches exactly one flit per credit, `error_credit_violation` never asserts, tracker `errors` stay 00.
- Assert `reset` while in TWO -> next cycle `out_valid`=0, `in_ready`=1, stale flits never appear on `out_data` valid cycles.
- With `C_FLIT_SENDER_STATS_EN`: head blocked by `credit_full` for 10 cycles -> `stall_count`=10. Force 70000 blocked cycles -> 16'hFFFF. Without the macro -> `stall_count`=0 throughout.

Source files
------------

// File: rtl/c_credit_flit_sender.sv
// Credit-gated two-entry output stage: launches a flit only while the downstream tracker is not full.
// Optional stall/almost-full statistics enabled by defining C_FLIT_SENDER_STATS_EN.
module c_credit_flit_sender #(
  parameter int unsigned data_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active,
  input  logic                  in_valid,
  input  logic [data_width-1:0] in_data,
  output logic                  in_ready,
  input  logic                  credit_full,
  input  logic                  credit_almost_full,
  output logic                  out_valid,
  output logic [data_width-1:0] out_data,
  output logic [15:0]           stall_count,
  output logic [0:1]            errors
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t                r_state, w_state_nxt;
  logic [data_width-1:0] r_head_data, r_skid_data, w_head_data_nxt, w_skid_data_nxt;
  logic                  r_head_valid, r_skid_valid, w_head_valid_nxt, w_skid_valid_nxt;
  logic                  w_accept, w_send;

  // Ready decodes registered occupancy only; no path from credit_full.
  assign in_ready  = active & (r_state != TWO);
  assign w_accept  = in_valid & in_ready;
  assign w_send    = r_head_valid & ~credit_full & active;
  assign out_valid = w_send;
  assign out_data  = r_head_data;
  assign errors    = {in_valid & ~in_ready & active, w_send & credit_full};

  always_comb begin
    w_state_nxt      = r_state;
    w_head_data_nxt  = r_head_data;
    w_head_valid_nxt = r_head_valid;
    w_skid_data_nxt  = r_skid_data;
    w_skid_valid_nxt = r_skid_valid;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_head_data_nxt  = in_data;
          w_head_valid_nxt = 1'b1;
          w_state_nxt      = ONE;
        end
      end
      ONE: begin
        if (w_accept && !w_send) begin
          w_skid_data_nxt  = in_data;
          w_skid_valid_nxt = 1'b1;
          w_state_nxt      = TWO;
        end else if (!w_accept && w_send) begin
          w_head_valid_nxt = 1'b0;
          w_state_nxt      = EMPTY;
        end else if (w_accept && w_send) begin
          w_head_data_nxt  = in_data;
        end
      end
      TWO: begin
        if (w_send) begin
          w_head_data_nxt  = r_skid_data;
          w_head_valid_nxt = 1'b1;
          w_skid_valid_nxt = 1'b0;
          w_state_nxt      = ONE;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= EMPTY;
      r_head_data  <= '0;
      r_head_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
    end else if (active) begin
      r_state      <= w_state_nxt;
      r_head_data  <= w_head_data_nxt;
      r_head_valid <= w_head_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_skid_valid <= w_skid_valid_nxt;
    end
  end

`ifdef C_FLIT_SENDER_STATS_EN
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_af_send_cnt;
  logic             w_unused_af_stats;

  // Saturating counters; the almost-full send count is observed hierarchically only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
      r_af_send_cnt <= '0;
    end else begin
      if (r_head_valid && credit_full && active && (r_stall_count != '1))
        r_stall_count <= r_stall_count + CNT_W'(1);
      if (credit_almost_full && w_send && (r_af_send_cnt != '1))
        r_af_send_cnt <= r_af_send_cnt + CNT_W'(1);
    end
  end

  assign stall_count       = r_stall_count;
  assign w_unused_af_stats = ^r_af_send_cnt;
`else
  logic w_unused_af;

  assign stall_count = 16'h0000;
  assign w_unused_af = credit_almost_full;
`endif

endmodule

// File: tb/tb_c_credit_flit_sender.sv
// Scoreboard bench for c_credit_flit_sender: directed stimulus queues expected flits, a negedge monitor checks launches.
module tb_c_credit_flit_sender;

  logic        clk = 1'b0;
  logic        reset, active, in_valid, in_ready;
  logic [31:0] in_data, out_data;
  logic        credit_full, credit_almost_full, out_valid;
  logic [15:0] stall_count;
  logic [0:1]  errors;

  logic        man_full, use_trk, pop;
  int          trk_count = 0;
  int          trk_err   = 0;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_launch = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  c_credit_flit_sender #(.data_width(32)) dut (
    .clk(clk), .reset(reset), .active(active),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .credit_full(credit_full), .credit_almost_full(credit_almost_full),
    .out_valid(out_valid), .out_data(out_data),
    .stall_count(stall_count), .errors(errors)
  );

  // Depth-2 credit tracker model closing the loop when use_trk is set.
  always_comb begin
    credit_full        = use_trk ? (trk_count == 2) : man_full;
    credit_almost_full = use_trk ? (trk_count == 1) : 1'b0;
  end

  always @(posedge clk) begin
    if (use_trk) begin
      if (out_valid && trk_count == 2) trk_err <= trk_err + 1;
      if (pop && trk_count == 0)       trk_err <= trk_err + 1;
      trk_count <= trk_count + (out_valid ? 1 : 0) - (pop ? 1 : 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every launch must match the oldest expected flit.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      n_launch++;
      chk("credit_violation", 32'(errors[1]), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_launch", out_data, 32'hDEAD_BEEF);
      end else begin
        chk("launch_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic offer(input logic [31:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      step();
      @(negedge clk);
      t++;
    end
    chk("offer_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(d);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b1; active = 1'b1; in_valid = 1'b0; in_data = '0;
    man_full = 1'b0; use_trk = 1'b0; pop = 1'b0;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_errors", 32'(errors), 32'd0);
    chk("rst_stall", 32'(stall_count), 32'd0);
    step();

    // Stream of 4 flits, one per cycle, 1-cycle latency
    base = n_launch;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA000_0000 + 32'(i);
      exp_q.push_back(in_data);
      @(negedge clk);
      chk("stream_ready", 32'(in_ready), 32'd1);
      chk("stream_valid", 32'(out_valid), (i > 0) ? 32'd1 : 32'd0);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last", 32'(out_valid), 32'd1);
    step();
    @(negedge clk);
    chk("stream_idle", 32'(out_valid), 32'd0);
    chk("stream_count", 32'(n_launch - base), 32'd4);

    // credit_full held: fill to TWO, third offer overflows
    step();
    man_full = 1'b1;
    in_valid = 1'b1; in_data = 32'hB000_0000; exp_q.push_back(in_data);
    @(negedge clk);
    chk("fill0_ready", 32'(in_ready), 32'd1);
    chk("fill0_err", 32'(errors), 32'd0);
    step();
    in_data = 32'hB000_0001; exp_q.push_back(in_data);
    @(negedge clk);
    chk("fill1_ready", 32'(in_ready), 32'd1);
    step();
    in_data = 32'hB000_0002;
    @(negedge clk);
    chk("fill2_ready", 32'(in_ready), 32'd0);
    chk("fill2_overflow", 32'(errors), 32'd2);
    chk("fill2_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("fill_err_clear", 32'(errors), 32'd0);
    chk("fill_still_two", 32'(in_ready), 32'd0);

    // Single-cycle credit windows drain oldest first
    step();
    man_full = 1'b0;
    @(negedge clk);
    chk("drain0_valid", 32'(out_valid), 32'd1);
    chk("drain0_ready", 32'(in_ready), 32'd0);
    step();
    man_full = 1'b1;
    @(negedge clk);
    chk("drain0_ready_next", 32'(in_ready), 32'd1);
    chk("drain0_hold", 32'(out_valid), 32'd0);
    step(); step();
    man_full = 1'b0;
    @(negedge clk);
    chk("drain1_valid", 32'(out_valid), 32'd1);
    step();
    @(negedge clk);
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    step();

    // Closed loop with depth-2 tracker, one credit every 3 cycles
    use_trk = 1'b1;
    fork
      begin : offerer
        for (int i = 0; i < 6; i++) offer(32'hC000_0000 + 32'(i));
      end
      begin : popper
        int t;
        t = 0;
        while (trk_count != 2 && t < 200) begin step(); t++; end
        chk("trk_fill", 32'(trk_count), 32'd2);
        repeat (3) step();
        for (int k = 0; k < 4; k++) begin
          int nl;
          nl = 0;
          pop = 1'b1;
          for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (out_valid) nl++;
            step();
            pop = 1'b0;
          end
          chk("launch_per_credit", 32'(nl), 32'd1);
        end
      end
    join
    chk("trk_errors", 32'(trk_err), 32'd0);
    chk("trk_queue", 32'(exp_q.size()), 32'd0);
`ifdef C_FLIT_SENDER_STATS_EN
    chk("af_send_cnt", 32'(dut.r_af_send_cnt), 32'd5);
`endif
    use_trk = 1'b0;
    man_full = 1'b0;
    step();

    // Reset while in TWO discards stale flits
    man_full = 1'b1;
    in_valid = 1'b1; in_data = 32'hEEEE_0000;
    step();
    in_data = 32'hEEEE_0001;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_two", 32'(in_ready), 32'd0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    man_full = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_data", out_data, 32'd0);
    repeat (3) begin
      step();
      @(negedge clk);
      chk("post_rst_quiet", 32'(out_valid), 32'd0);
    end
    step();

    // Stall counter, saturation, and clock-enable freeze
    man_full = 1'b1;
    in_valid = 1'b1; in_data = 32'hD000_0000; exp_q.push_back(in_data);
    step();
    in_valid = 1'b0;
    repeat (10) step();
    @(negedge clk);
`ifdef C_FLIT_SENDER_STATS_EN
    chk("stall_10", 32'(stall_count), 32'd10);
    repeat (70000) step();
    @(negedge clk);
    chk("stall_sat", 32'(stall_count), 32'h0000_FFFF);
`else
    chk("stall_off", 32'(stall_count), 32'd0);
`endif
    step();
    active = 1'b0;
    man_full = 1'b0;
    in_valid = 1'b1; in_data = 32'hD000_0001;
    @(negedge clk);
    chk("inactive_valid", 32'(out_valid), 32'd0);
    chk("inactive_ready", 32'(in_ready), 32'd0);
    chk("inactive_err", 32'(errors), 32'd0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("inactive_hold", 32'(out_valid), 32'd0);
    step();
    active = 1'b1;
    @(negedge clk);
    chk("active_resume", 32'(out_valid), 32'd1);
    step();
    @(negedge clk);
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("stall_rst", 32'(stall_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
